mem_write_checker: RTL and testbench

- Synthesizable self-check block that watches the core's data-memory write port (mem_write, data_addr, write_data) and decides pass, fail or timeout.
- Generalises the single-result store check into a programmable ordered table of NUM_EXP expected writes.
- Adds a configurable ignored-address window, a write counter, a cycle timeout and captured failure information.
- Sits beside the top-level core in simulation and FPGA bring-up builds; its status outputs drive the bench and board LEDs.

---
 rtl/mem_write_checker_pkg.sv | 24 ++
 rtl/mem_write_checker_timeout_ctr.sv | 34 +++
 rtl/mem_write_checker.sv | 188 ++++++++++++++++++
 tb/tb_mem_write_checker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_checker_pkg.sv
// Shared types and defaults for mem_write_checker.
// Holds the FSM state enum, the expected-write entry struct and the reset defaults.
package mem_write_checker_pkg;

  localparam int CHK_ADDR_W = 32;
  localparam int CHK_DATA_W = 32;
  localparam int DEF_ADDR_C = 100;
  localparam int DEF_DATA_C = 25;
  localparam int DEF_NUM_C  = 1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TOUT
  } chk_state_t;

  typedef struct packed {
    logic [CHK_ADDR_W-1:0] addr;
    logic [CHK_DATA_W-1:0] data;
  } exp_entry_t;

endpackage

// File: rtl/mem_write_checker_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag.
// A terminal count of 0 disables the flag entirely.
module chk_timeout_ctr #(
  parameter int TC = 10000,
  parameter int W  = (TC > 1) ? $clog2(TC) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TCM = W'((TC > 0) ? TC - 1 : 0);
  localparam bit ON = (TC > 0);

  logic [W-1:0] cnt;
  logic         hit;

  assign hit = (cnt == TCM);
  assign tc  = ON & hit;

  // Count RUN cycles, holding once the terminal count is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Watches the core's data-memory write port against an ordered expected-write table.
// Optional MEM_WRITE_CHECKER_HIST_EN adds a 4-deep history of checked writes.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 4,
  parameter int IDX_W       = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  parameter int CNT_W       = 16,
  parameter int IGN_BASE    = 96,
  parameter int IGN_LIMIT   = 96,
  parameter int TIMEOUT_CYC = 10000,
  parameter int DEF_ADDR    = DEF_ADDR_C,
  parameter int DEF_DATA    = DEF_DATA_C,
  parameter int DEF_NUM     = DEF_NUM_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_num,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  wr_count,
  output logic [IDX_W-1:0]  exp_idx,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
`ifdef MEM_WRITE_CHECKER_HIST_EN
  ,
  output logic [ADDR_W-1:0] hist_addr [4],
  output logic [DATA_W-1:0] hist_data [4]
`endif
);

  localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(NUM_EXP);
  localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

  chk_state_t     state_q;
  chk_state_t     state_d;
  exp_entry_t     tbl [NUM_EXP];
  exp_entry_t     cur;
  logic [IDX_W:0] num_q;
  logic [IDX_W:0] num_c;
  logic           ign;
  logic           hit_exp;
  logic           last;
  logic           wr_run;
  logic           chk;
  logic           tc;

  assign cur     = tbl[exp_idx];
  assign ign     = (data_addr >= ADDR_W'(IGN_BASE)) &&
                   (data_addr <= ADDR_W'(IGN_LIMIT));
  assign hit_exp = (data_addr == ADDR_W'(cur.addr)) &&
                   (write_data == DATA_W'(cur.data));
  assign last    = ({1'b0, exp_idx} == (num_q - ONE));
  assign wr_run  = (state_q == RUN) && mem_write && !start;
  assign chk     = wr_run && !ign;

  assign busy    = (state_q == RUN);
  assign pass    = (state_q == PASS);
  assign fail    = (state_q == FAIL);
  assign timeout = (state_q == TOUT);
  assign done    = pass | fail | timeout;

  chk_timeout_ctr #(
    .TC (TIMEOUT_CYC)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (state_q == RUN),
    .tc  (tc)
  );

  // Clamp the requested active-entry count into 1..NUM_EXP.
  always_comb begin
    num_c = cfg_num;
    if (cfg_num == '0) begin
      num_c = ONE;
    end else if (cfg_num > NUM_MAX) begin
      num_c = NUM_MAX;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start beats a decided write, which beats the timeout.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (chk && !hit_exp) begin
        state_d = FAIL;
      end else if (chk && last) begin
        state_d = PASS;
      end else if (tc) begin
        state_d = TOUT;
      end
    end
  end

  // Expected-write table and active count; frozen while a run is live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        tbl[i] <= '0;
      end
      tbl[0].addr <= CHK_ADDR_W'(DEF_ADDR);
      tbl[0].data <= CHK_DATA_W'(DEF_DATA);
      num_q       <= (IDX_W+1)'(DEF_NUM);
    end else if (cfg_we && state_q != RUN) begin
      tbl[cfg_idx].addr <= CHK_ADDR_W'(cfg_addr);
      tbl[cfg_idx].data <= CHK_DATA_W'(cfg_data);
      num_q             <= num_c;
    end
  end

  // Write counter, table pointer and capture of the offending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
      exp_idx  <= '0;
      err_addr <= '0;
      err_data <= '0;
    end else if (start) begin
      wr_count <= '0;
      exp_idx  <= '0;
      err_addr <= '0;
      err_data <= '0;
    end else if (wr_run) begin
      if (wr_count != '1) begin
        wr_count <= wr_count + CNT_W'(1);
      end
      if (!ign) begin
        if (hit_exp) begin
          exp_idx <= exp_idx + IDX_W'(1);
        end else begin
          err_addr <= data_addr;
          err_data <= write_data;
        end
      end
    end
  end

`ifdef MEM_WRITE_CHECKER_HIST_EN
  // Newest-first shift history of checked writes; stops once out of RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else if (start) begin
      for (int i = 0; i < 4; i++) begin
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else if (chk) begin
      for (int i = 3; i > 0; i--) begin
        hist_addr[i] <= hist_addr[i-1];
        hist_data[i] <= hist_data[i-1];
      end
      hist_addr[0] <= data_addr;
      hist_data[0] <= write_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed self-checking bench for mem_write_checker.
// Runs the DUT with a 50-cycle timeout.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic [2:0]  cfg_num;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [15:0] wr_count;
  logic [1:0]  exp_idx;
  logic [31:0] err_addr;
  logic [31:0] err_data;
`ifdef MEM_WRITE_CHECKER_HIST_EN
  logic [31:0] hist_addr [4];
  logic [31:0] hist_data [4];
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_write_checker #(
    .TIMEOUT_CYC (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_write  (mem_write),
    .data_addr  (data_addr),
    .write_data (write_data),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_num    (cfg_num),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .wr_count   (wr_count),
    .exp_idx    (exp_idx),
    .err_addr   (err_addr),
    .err_data   (err_data)
`ifdef MEM_WRITE_CHECKER_HIST_EN
    ,
    .hist_addr  (hist_addr),
    .hist_data  (hist_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_write  = 1'b1;
    data_addr  = a;
    write_data = d;
    step();
    mem_write  = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] i, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] n);
    cfg_we   = 1'b1;
    cfg_idx  = i;
    cfg_addr = a;
    cfg_data = d;
    cfg_num  = n;
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    mem_write  = 1'b0;
    data_addr  = '0;
    write_data = '0;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_num    = '0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wrcnt", wr_count, 16'd0);
    chk("rst_erra", err_addr, 32'd0);
    rst = 1'b1;
    step();
    chk("idle_busy", busy, 1'b0);

    // Default table: scratch write ignored, then the result store.
    do_start();
    chk("t1_busy", busy, 1'b1);
    wr(32'd96, 32'd7);
    chk("t1_wrcnt1", wr_count, 16'd1);
    chk("t1_busy1", busy, 1'b1);
    wr(32'd100, 32'd25);
    chk("t1_pass", pass, 1'b1);
    chk("t1_done", done, 1'b1);
    chk("t1_fail", fail, 1'b0);
    chk("t1_wrcnt2", wr_count, 16'd2);
    wr(32'd100, 32'd25);
    chk("t1_frozen", wr_count, 16'd2);

    // Wrong data at the expected address.
    do_start();
    chk("t2_wrcnt0", wr_count, 16'd0);
    wr(32'd100, 32'd24);
    chk("t2_fail", fail, 1'b1);
    chk("t2_pass", pass, 1'b0);
    chk("t2_erra", err_addr, 32'd100);
    chk("t2_errd", err_data, 32'd24);
    chk("t2_idx", exp_idx, 2'd0);

    // Three-entry table with an ignored write in the middle.
    cfg(2'd0, 32'd8, 32'd1, 3'd3);
    cfg(2'd1, 32'd12, 32'd2, 3'd3);
    cfg(2'd2, 32'd16, 32'd3, 3'd3);
    do_start();
    chk("t3_erra_clr", err_addr, 32'd0);
    wr(32'd8, 32'd1);
    chk("t3_idx1", exp_idx, 2'd1);
    wr(32'd96, 32'd0);
    chk("t3_idx_ign", exp_idx, 2'd1);
    wr(32'd12, 32'd2);
    chk("t3_idx2", exp_idx, 2'd2);
    chk("t3_busy", busy, 1'b1);
    wr(32'd16, 32'd3);
    chk("t3_pass", pass, 1'b1);
    chk("t3_wrcnt", wr_count, 16'd4);
    chk("t3_idx3", exp_idx, 2'd3);
    do_start();
    chk("t3_idx0", exp_idx, 2'd0);

    // Asynchronous reset in the middle of a run.
    wr(32'd8, 32'd1);
    chk("t4_idx1", exp_idx, 2'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_idx", exp_idx, 2'd0);
    chk("t4_wrcnt", wr_count, 16'd0);
    chk("t4_done", done, 1'b0);
    step();
    rst = 1'b1;
    do_start();
    wr(32'd100, 32'd25);
    chk("t4_def_pass", pass, 1'b1);

    // Configuration attempts during RUN are dropped.
    do_start();
    cfg(2'd0, 32'd100, 32'd99, 3'd1);
    chk("t5_busy", busy, 1'b1);
    wr(32'd100, 32'd25);
    chk("t5_pass", pass, 1'b1);

    // Count above NUM_EXP clamps to 4; entries 1..3 are zero.
    cfg(2'd0, 32'd100, 32'd25, 3'd7);
    do_start();
    wr(32'd100, 32'd25);
    chk("t6_busy", busy, 1'b1);
    wr(32'd0, 32'd0);
    wr(32'd0, 32'd0);
    chk("t6_idx3", exp_idx, 2'd3);
    wr(32'd0, 32'd0);
    chk("t6_pass", pass, 1'b1);
    chk("t6_idxwrap", exp_idx, 2'd0);

    // Count of zero clamps to 1.
    cfg(2'd0, 32'd100, 32'd25, 3'd0);
    do_start();
    wr(32'd100, 32'd25);
    chk("t7_pass", pass, 1'b1);

    // Timeout with no writes.
    do_start();
    for (int i = 0; i < 49; i++) step();
    chk("t8_tout49", timeout, 1'b0);
    chk("t8_busy49", busy, 1'b1);
    step();
    chk("t8_tout50", timeout, 1'b1);
    chk("t8_done", done, 1'b1);

    // Final match on the timeout cycle wins.
    do_start();
    chk("t9_tout_clr", timeout, 1'b0);
    for (int i = 0; i < 49; i++) step();
    wr(32'd100, 32'd25);
    chk("t9_pass", pass, 1'b1);
    chk("t9_tout", timeout, 1'b0);

    // Mismatch on the timeout cycle wins.
    do_start();
    for (int i = 0; i < 49; i++) step();
    wr(32'd100, 32'd1);
    chk("t10_fail", fail, 1'b1);
    chk("t10_tout", timeout, 1'b0);
    chk("t10_errd", err_data, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
